// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and defaults for the load/store controller
package lsu_pkg;

  localparam int LSU_XLEN    = 32;
  localparam int LSU_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // funct3[1:0] encoding; SIZE_ILL is kept so an illegal size can be carried and rejected
  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALF     = 2'd1,
    WORD     = 2'd2,
    SIZE_ILL = 2'd3
  } lsu_size_e;

  typedef struct packed {
    logic [LSU_XLEN-1:0] addr;
    lsu_size_e           size;
    logic                is_unsigned;
    logic                is_store;
    logic [4:0]          rd;
    logic [LSU_XLEN-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - execute, memory-stage and writeback signals of the load/store controller
interface lsu_ctrl_if import lsu_pkg::*; #(
  parameter int XLEN = LSU_XLEN
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_base;
  logic [XLEN-1:0]   req_offset;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              l_valid;
  logic              s_valid;
  logic              load_finish;
  logic              store_finish;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic [4:0]        resp_rd;
  logic              resp_err;
  logic              busy;

  // master: surrounding pipeline and memory stage; slave: the controller
  modport master (
    output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
    output load_finish, store_finish, mem_rdata, resp_ready,
    input  req_ready, l_valid, s_valid, mem_addr, mem_wdata, mem_wstrb,
    input  resp_valid, resp_data, resp_rd, resp_err, busy
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
    input  load_finish, store_finish, mem_rdata, resp_ready,
    output req_ready, l_valid, s_valid, mem_addr, mem_wdata, mem_wstrb,
    output resp_valid, resp_data, resp_rd, resp_err, busy
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - alignment check, store lane replication/strobe and load extract/extension
module lsu_align import lsu_pkg::*; #(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [1:0]        addr_lo_i,
  input  lsu_size_e         size_i,
  input  logic              is_unsigned_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic              misaligned_o,
  output logic [XLEN-1:0]   lane_wdata_o,
  output logic [XLEN/8-1:0] lane_wstrb_o,
  output logic [XLEN-1:0]   load_data_o
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted      = rdata_i >> {addr_lo_i, 3'b000};
    misaligned_o = 1'b0;
    lane_wdata_o = wdata_i;
    lane_wstrb_o = '1;
    load_data_o  = shifted;
    case (size_i)
      BYTE: begin
        lane_wdata_o = {NB{wdata_i[7:0]}};
        lane_wstrb_o = NB'(1) << addr_lo_i;
        load_data_o  = {{(XLEN-8){~is_unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        misaligned_o = addr_lo_i[0];
        lane_wdata_o = {(NB/2){wdata_i[15:0]}};
        lane_wstrb_o = NB'(3) << addr_lo_i;
        load_data_o  = {{(XLEN-16){~is_unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      WORD:    misaligned_o = |addr_lo_i;
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - one-at-a-time load/store controller between execute and the memory stage
module lsu_ctrl import lsu_pkg::*; #(
  parameter int XLEN    = LSU_XLEN,
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic       clk,
  input  logic       rstn,
  lsu_ctrl_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 2);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d, new_req;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic [1:0]        sel_addr_lo;
  lsu_size_e         sel_size;
  logic              sel_unsigned;
  logic [XLEN-1:0]   sel_wdata;
  logic              misaligned;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN/8-1:0] lane_wstrb;
  logic [XLEN-1:0]   load_data;
  logic              finish_hit;

  always_comb begin
    new_req.addr        = bus.req_base + bus.req_offset;
    new_req.size        = lsu_size_e'(bus.req_funct3[1:0]);
    new_req.is_unsigned = bus.req_funct3[2];
    new_req.is_store    = bus.req_is_store;
    new_req.rd          = bus.req_rd;
    new_req.wdata       = bus.req_wdata;
  end

  // The single align unit checks the incoming request in IDLE and serves the held request afterwards
  assign sel_addr_lo  = (state_q == IDLE) ? new_req.addr[1:0]   : req_q.addr[1:0];
  assign sel_size     = (state_q == IDLE) ? new_req.size        : req_q.size;
  assign sel_unsigned = (state_q == IDLE) ? new_req.is_unsigned : req_q.is_unsigned;
  assign sel_wdata    = (state_q == IDLE) ? new_req.wdata       : req_q.wdata;

  lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo_i     (sel_addr_lo),
    .size_i        (sel_size),
    .is_unsigned_i (sel_unsigned),
    .wdata_i       (sel_wdata),
    .rdata_i       (bus.mem_rdata),
    .misaligned_o  (misaligned),
    .lane_wdata_o  (lane_wdata),
    .lane_wstrb_o  (lane_wstrb),
    .load_data_o   (load_data)
  );

  assign finish_hit = req_q.is_store ? bus.store_finish : bus.load_finish;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d       = new_req;
          resp_data_d = '0;
          resp_err_d  = misaligned;
          state_d     = misaligned ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (finish_hit) begin
          if (!req_q.is_store) resp_data_d = load_data;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          resp_err_d  = 1'b1;
          resp_data_d = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.l_valid    = (state_q == ISSUE) && !req_q.is_store;
  assign bus.s_valid    = (state_q == ISSUE) &&  req_q.is_store;
  assign bus.mem_addr   = {req_q.addr[XLEN-1:2], 2'b00};
  assign bus.mem_wdata  = (state_q == IDLE) ? '0 : lane_wdata;
  assign bus.mem_wstrb  = ((state_q == ISSUE) && req_q.is_store) ? lane_wstrb : '0;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = req_q.rd;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with directed load/store vectors
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.XLEN(XLEN)) bus ();

  lsu_ctrl #(.XLEN(XLEN), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   l_cnt = 0;
  int   s_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor and issue-pulse counter, sampled away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (bus.l_valid) l_cnt++;
    if (bus.s_valid) s_cnt++;
    if (bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected response", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_data", bus.resp_data, e.data);
        check("resp_rd", {27'd0, bus.resp_rd}, {27'd0, e.rd});
        check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_base     = base;
    bus.req_offset   = off;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    check({nm, " back to idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({nm, " l_valid"}, {31'd0, bus.l_valid}, 32'd0);
    check({nm, " s_valid"}, {31'd0, bus.s_valid}, 32'd0);
    check({nm, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    check({nm, " resp_err"}, {31'd0, bus.resp_err}, 32'd0);
    check({nm, " busy"}, {31'd0, bus.busy}, 32'd0);
    check({nm, " resp_data"}, bus.resp_data, 32'd0);
    check({nm, " resp_rd"}, {27'd0, bus.resp_rd}, 32'd0);
    check({nm, " mem_addr"}, bus.mem_addr, 32'd0);
    check({nm, " mem_wdata"}, bus.mem_wdata, 32'd0);
    check({nm, " mem_wstrb"}, {28'd0, bus.mem_wstrb}, 32'd0);
  endtask

  // Full operation with mem_ls-style timing: finish in T+2, response in T+3
  task automatic run_op(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input logic [31:0] exp_data, input logic exp_err,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                        input logic [3:0] exp_strb);
    int l0, s0;
    l0 = l_cnt;
    s0 = s_cnt;
    exp_q.push_back('{exp_data, rd, exp_err});
    present(st, f3, base, off, wd, rd);
    if (exp_err) begin
      check({nm, " resp_valid at T+1"}, {31'd0, bus.resp_valid}, 32'd1);
    end else begin
      check({nm, " l_valid at T+1"}, {31'd0, bus.l_valid}, {31'd0, !st});
      check({nm, " s_valid at T+1"}, {31'd0, bus.s_valid}, {31'd0, st});
      check({nm, " mem_addr"}, bus.mem_addr, exp_addr);
      if (st) begin
        check({nm, " mem_wdata"}, bus.mem_wdata, exp_wd);
        check({nm, " mem_wstrb"}, {28'd0, bus.mem_wstrb}, {28'd0, exp_strb});
      end
      tick();
      if (st) bus.store_finish = 1'b1;
      else    bus.load_finish  = 1'b1;
      bus.mem_rdata = rdata;
      tick();
      bus.store_finish = 1'b0;
      bus.load_finish  = 1'b0;
      check({nm, " resp_valid at T+3"}, {31'd0, bus.resp_valid}, 32'd1);
    end
    wait_idle(nm);
    check({nm, " l_valid pulses"}, l_cnt - l0, (!exp_err && !st) ? 32'd1 : 32'd0);
    check({nm, " s_valid pulses"}, s_cnt - s0, (!exp_err && st) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int l0;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'd0;
    bus.req_base     = '0;
    bus.req_offset   = '0;
    bus.req_wdata    = '0;
    bus.req_rd       = '0;
    bus.load_finish  = 1'b0;
    bus.store_finish = 1'b0;
    bus.mem_rdata    = '0;
    bus.resp_ready   = 1'b1;
    #1;
    check_reset_values("reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();

    run_op("byte load signed", 1'b0, 3'd0, 32'h1000, 32'd3, 32'd0, 5'd5, 32'h80FF_0000,
           32'hFFFF_FF80, 1'b0, 32'h1000, 32'd0, 4'd0);
    run_op("byte load unsigned", 1'b0, 3'd4, 32'h1000, 32'd3, 32'd0, 5'd6, 32'h80FF_0000,
           32'h0000_0080, 1'b0, 32'h1000, 32'd0, 4'd0);
    run_op("half store", 1'b1, 3'd1, 32'h2000, 32'd2, 32'h1234_ABCD, 5'd0, 32'd0,
           32'd0, 1'b0, 32'h2000, 32'hABCD_ABCD, 4'b1100);
    run_op("misaligned word", 1'b0, 3'd2, 32'h3000, 32'd1, 32'd0, 5'd10, 32'd0,
           32'd0, 1'b1, 32'd0, 32'd0, 4'd0);
    run_op("illegal size", 1'b0, 3'd3, 32'h3000, 32'd0, 32'd0, 5'd11, 32'd0,
           32'd0, 1'b1, 32'd0, 32'd0, 4'd0);

    // Timeout: WAIT entry at T+2, error response TIMEOUT+1 = 9 cycles later
    l0 = l_cnt;
    exp_q.push_back('{32'd0, 5'd7, 1'b1});
    present(1'b0, 3'd2, 32'h5000, 32'd0, 32'd0, 5'd7);
    check("timeout l_valid", {31'd0, bus.l_valid}, 32'd1);
    repeat (9) tick();
    check("timeout resp_valid early", {31'd0, bus.resp_valid}, 32'd0);
    tick();
    check("timeout resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    wait_idle("timeout");
    check("timeout l_valid pulses", l_cnt - l0, 32'd1);

    run_op("wrapped word load", 1'b0, 3'd2, 32'hFFFF_FFFC, 32'd8, 32'd0, 5'd12, 32'hDEAD_BEEF,
           32'hDEAD_BEEF, 1'b0, 32'h0000_0004, 32'd0, 4'd0);

    // Backpressure with a stray store_finish in WAIT and a stray load_finish in RESP
    l0 = l_cnt;
    bus.resp_ready = 1'b0;
    exp_q.push_back('{32'hFFFF_8001, 5'd9, 1'b0});
    present(1'b0, 3'd1, 32'h6000, 32'd2, 32'd0, 5'd9);
    tick();
    bus.store_finish = 1'b1;
    tick();
    bus.store_finish = 1'b0;
    check("stray store_finish ignored", {30'd0, bus.busy, bus.resp_valid}, 32'd2);
    bus.load_finish = 1'b1;
    bus.mem_rdata   = 32'h8001_1234;
    tick();
    bus.load_finish = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("held resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("held resp_data", bus.resp_data, 32'hFFFF_8001);
      check("held resp_rd", {27'd0, bus.resp_rd}, 32'd9);
      check("held req_ready", {31'd0, bus.req_ready}, 32'd0);
      bus.load_finish = (i == 1);
      tick();
    end
    bus.load_finish = 1'b0;
    bus.resp_ready  = 1'b1;
    wait_idle("backpressure");
    check("backpressure l_valid pulses", l_cnt - l0, 32'd1);

    // Reset asserted during WAIT
    l0 = l_cnt;
    present(1'b0, 3'd2, 32'h7000, 32'd0, 32'd0, 5'd3);
    tick();
    rstn = 1'b0;
    #1;
    check_reset_values("mid-op reset");
    tick();
    tick();
    rstn = 1'b1;
    repeat (5) tick();
    check("no pulse after reset", l_cnt - l0, 32'd1);
    check("idle after reset", {31'd0, bus.busy}, 32'd0);

    run_op("byte store after reset", 1'b1, 3'd0, 32'h8000, 32'd1, 32'h0000_0055, 5'd4, 32'd0,
           32'd0, 1'b0, 32'h8000, 32'h5555_5555, 4'b0010);

    repeat (3) tick();
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the execute stage and the memory load/store stage (`mem_ls`). It accepts one memory operation at a time and computes the effective address. It then issues a single-cycle `l_valid`/`s_valid` pulse and waits for the matching `load_finish`/`store_finish`. Finally it returns aligned, extended load data (or store completion) to writeback with a valid/ready handshake, and flags misaligned accesses and memory timeouts.

## Interface
Parameters:
- `XLEN`, default 32: data/address width.
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before an error response.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  execute stage offers an operation.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  [1:0] size (0 = byte, 1 = half, 2 = word, 3 = illegal); [2] = unsigned load.
- `req_base`, `req_offset`  in  XLEN  address operands.
- `req_wdata`  in  XLEN  store data, LSB-aligned.
- `req_rd`  in  5  destination register tag.
- `l_valid`, `s_valid`  out  1  single-cycle issue pulses to the memory stage.
- `load_finish`, `store_finish`  in  1  completion pulses from the memory stage.
- `mem_addr`  out  XLEN  word-aligned address, {addr[XLEN-1:2], 2'b00}.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_wstrb`  out  XLEN/8  byte-lane enables.
- `mem_rdata`  in  XLEN  read word, sampled on `load_finish`.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  writeback accepts the response.
- `resp_data`  out  XLEN  extended load result; 0 for stores and errors.
- `resp_rd`  out  5  tag echoed from the request.
- `resp_err`  out  1  misaligned, illegal size, or timeout.
- `busy`  out  1  high whenever the state is not IDLE (pipeline stall).

## Operation
States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, register the request: `addr = req_base + req_offset`, mod 2^XLEN, carry discarded.
  - Register `size`, `unsigned`, `is_store`, `rd` and `wdata`.
  - Size 3, half with addr[0] = 1, or word with addr[1:0] ≠ 0: go to RESP with `err` = 1. No memory pulse is issued.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Exactly one cycle: `l_valid` = !is_store, `s_valid` = is_store.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` are valid in this cycle.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - Only the finish signal matching the operation type is honoured; the other is ignored.
  - On the matching finish, a load captures the extracted `mem_rdata` into `resp_data`; then go to RESP.
  - The counter increments every cycle without the matching finish. When it equals TIMEOUT, go to RESP with `err` = 1 and `resp_data` = 0.
- **RESP**
  - `resp_valid` = 1; `resp_*` are held stable until `resp_ready`.
  - On `resp_ready`, go to IDLE.

Store lanes:
- Byte: `wdata[7:0]` replicated ×4, `wstrb` = 1 << addr[1:0].
- Half: `wdata[15:0]` replicated ×2, `wstrb` = 4'b0011 << addr[1:0].
- Word: `wstrb` = 4'b1111.

Load extract:
- `rdata >> (addr[1:0]*8)`, truncated to the access size.
- Sign-extended, or zero-extended when `unsigned` = 1.

Finish pulses arriving in IDLE, ISSUE or RESP are ignored and must not change state.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `l_valid` = `s_valid` = 0, `resp_valid` = 0, `resp_err` = 0, `busy` = 0, and `resp_data`, `resp_rd`, `mem_addr`, `mem_wdata`, `mem_wstrb` = 0.
- Reset asserted mid-operation returns to IDLE immediately. No issue pulse may follow the deassertion of reset.
- Request accepted at the edge ending cycle T:
  - ISSUE in T+1 (pulse).
  - With `mem_ls`, `load_finish` arrives in T+2.
  - `resp_valid` in T+3.
  - With `resp_ready` in T+3, IDLE in T+4.
  - Minimum occupancy is 4 cycles.
- Misaligned or illegal request: `resp_valid` in T+1.
- Timeout: `resp_valid` appears TIMEOUT+1 cycles after WAIT entry.
- Issue pulses are never longer than one cycle and are never issued twice per request.

## Structure
- Package `lsu_pkg`:
  - `lsu_state_e` (IDLE/ISSUE/WAIT/RESP).
  - `lsu_size_e` (BYTE/HALF/WORD).
  - Request struct `lsu_req_t` {`addr`, `size`, `unsigned`, `is_store`, `rd`, `wdata`}.
  - Default `LSU_TIMEOUT` = 255.
- Sub-module `lsu_align`: purely combinational. Computes the misalign check, store lane replication and strobe, and load extract/extension. Instantiated once.

## Test plan
- **Byte load:** base 0x1000, offset 3, funct3 = 0, `mem_rdata` = 0x80FF_0000.
  - `l_valid` in T+1, `mem_addr` = 0x1000.
  - `resp_data` = 0xFFFF_FF80 in T+3.
  - Same access with funct3 = 4: `resp_data` = 0x0000_0080.
- **Half store:** addr 0x2002, `wdata` = 0x1234_ABCD.
  - `s_valid` single pulse, `mem_wdata` = 0xABCD_ABCD, `mem_wstrb` = 0b1100.
  - Response with `resp_data` = 0 and `resp_err` = 0.
- **Misaligned word load:** addr 0x3001.
  - No `l_valid`; `resp_valid` in T+1 with `resp_err` = 1.
  - Size 3 gives the same response.
- **Timeout:** TIMEOUT = 8, `load_finish` never asserted.
  - `resp_err` = 1 nine cycles after WAIT entry.
  - A later request proceeds normally.
- **Backpressure and spurious finish:**
  - Hold `resp_ready` = 0 for 5 cycles: `resp_*` stable, `req_ready` = 0.
  - A stray `store_finish` during a load WAIT is ignored.
- **Reset mid-operation:** `rstn` low during WAIT.
  - All outputs take reset values immediately.
  - No pulse appears after the deassertion of reset.
  - `address` 0xFFFF_FFFC + 8 wraps to 0x0000_0004.
